div_iter_ctrl: RTL and testbench

- Multi-cycle iterative (radix-2, restoring) integer divider with its sequencing FSM. It serves DIV.W/MOD.W/DIV.WU/MOD.WU in the EXE stage and replaces the vendor divider IP pair.
- The EXE stage issues one request per instruction over a valid/ready handshake. It stalls its ready_go until out_valid is asserted.
- A pipeline flush (exception/ertn) aborts any operation in flight.

---
 rtl/div_iter_ctrl_if.sv | 27 ++
 rtl/div_iter_ctrl.sv | 145 ++++++++++++++
 tb/tb_div_iter_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/div_iter_ctrl_if.sv
// Request/response bundle between the EXE stage and the iterative divider.
// The master side is the EXE stage and the slave side is the divider.
interface div_iter_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic             in_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;

  modport master (
    output in_valid, in_signed, dividend, divisor, flush, out_ready,
    input  in_ready, out_valid, quotient, remainder, busy
  );

  modport slave (
    input  in_valid, in_signed, dividend, divisor, flush, out_ready,
    output in_ready, out_valid, quotient, remainder, busy
  );
endinterface

// File: rtl/div_iter_ctrl.sv
// Radix-2 restoring divider for DIV.W/MOD.W/DIV.WU/MOD.WU, one quotient bit per cycle.
//   state  | meaning
//   IDLE   | ready for a request
//   PREP   | take magnitudes and signs, short-cut divide-by-zero
//   CALC   | WIDTH shift/trial-subtract steps, MSB first
//   FIX    | apply result signs
//   DONE   | result held until the consumer takes it
module div_iter_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            resetn,
  div_iter_ctrl_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t           r_state;
  logic             r_signed;
  logic             r_q_neg;
  logic             r_r_neg;
  logic [WIDTH-1:0] r_dvd_in;
  logic [WIDTH-1:0] r_dsr_in;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dsr;
  logic [WIDTH:0]   r_prem;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rmd;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;

  logic [WIDTH-1:0] w_dvd_abs;
  logic [WIDTH-1:0] w_dsr_abs;
  logic [WIDTH+1:0] w_shift;
  logic [WIDTH+1:0] w_trial;
  logic             w_qbit;

  assign w_dvd_abs = (r_signed && r_dvd_in[WIDTH-1]) ? -r_dvd_in : r_dvd_in;
  assign w_dsr_abs = (r_signed && r_dsr_in[WIDTH-1]) ? -r_dsr_in : r_dsr_in;

  // Partial remainder stays below |divisor|, so the top bit of the shift is
  // always zero and bit WIDTH+1 of the trial difference is a clean sign.
  assign w_shift = {r_prem, r_dvd[WIDTH-1]};
  assign w_trial = w_shift - {2'b00, r_dsr};
  assign w_qbit  = ~w_trial[WIDTH+1];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_signed    <= 1'b0;
      r_q_neg     <= 1'b0;
      r_r_neg     <= 1'b0;
      r_dvd_in    <= '0;
      r_dsr_in    <= '0;
      r_dvd       <= '0;
      r_dsr       <= '0;
      r_prem      <= '0;
      r_cnt       <= '0;
      r_quo       <= '0;
      r_rmd       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else if (bus.flush) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_dvd_in   <= bus.dividend;
            r_dsr_in   <= bus.divisor;
            r_signed   <= bus.in_signed;
            r_state    <= S_PREP;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        S_PREP: begin
          r_q_neg <= r_signed & (r_dvd_in[WIDTH-1] ^ r_dsr_in[WIDTH-1]);
          r_r_neg <= r_signed & r_dvd_in[WIDTH-1];
          if (r_dsr_in == '0) begin
            r_quo       <= '1;
            r_rmd       <= r_dvd_in;
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_dvd   <= w_dvd_abs;
            r_dsr   <= w_dsr_abs;
            r_prem  <= '0;
            r_cnt   <= '0;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_prem <= w_qbit ? w_trial[WIDTH:0] : w_shift[WIDTH:0];
          r_dvd  <= {r_dvd[WIDTH-2:0], w_qbit};
          r_cnt  <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH-1)) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_quo       <= r_q_neg ? -r_dvd : r_dvd;
          r_rmd       <= r_r_neg ? -r_prem[WIDTH-1:0] : r_prem[WIDTH-1:0];
          r_state     <= S_DONE;
          r_out_valid <= 1'b1;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.quotient  = r_quo;
  assign bus.remainder = r_rmd;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_div_iter_ctrl.sv
// Directed bench for div_iter_ctrl: stimulus pushes expected results into a
// scoreboard queue, a negedge monitor pops and compares on each handshake.
module tb_div_iter_ctrl;

  logic clk;
  logic resetn;

  div_iter_ctrl_if #(.WIDTH(32)) bus ();

  div_iter_ctrl #(.WIDTH(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a result counts only if it is handed over (valid && ready, no flush).
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resetn && bus.out_valid && bus.out_ready && !bus.flush) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got q=%h r=%h expected none", bus.quotient, bus.remainder);
        end else begin
          e = sb.pop_front();
          check("sb_quotient", bus.quotient, e.q);
          check("sb_remainder", bus.remainder, e.r);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Called at posedge+1 with a request driven; returns at posedge+1 after the accept edge.
  task automatic accept(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    bus.in_valid  = 1'b1;
    bus.in_signed = sgn;
    bus.dividend  = a;
    bus.divisor   = b;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("accept_busy", {31'b0, bus.busy}, 32'd1);
  endtask

  // Counts edges from the accept edge until out_valid is seen.
  task automatic wait_out(input int exp_lat, input string name);
    int lat;
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check(name, 32'(lat), 32'(exp_lat));
  endtask

  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] q, input logic [31:0] r, input int lat,
                        input string name);
    exp_t e;
    accept(sgn, a, b);
    e.q = q;
    e.r = r;
    sb.push_back(e);
    wait_out(lat, name);
    @(posedge clk); #1;
  endtask

  initial begin
    int seen;
    exp_t e;
    resetn        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_signed = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_quotient", bus.quotient, 32'd0);
    check("rst_remainder", bus.remainder, 32'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    run_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 35, "lat_100_7");
    check("idle_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("idle_busy", {31'b0, bus.busy}, 32'd0);

    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 35, "lat_m7_2");
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 35, "lat_7_m2");
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 35, "lat_ovf");
    run_op(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 35, "lat_m100_m7");
    run_op(1'b0, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 32'd15, 35, "lat_max_16");
    run_op(1'b0, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234, 2, "lat_div0_u");
    run_op(1'b1, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234, 2, "lat_div0_s");

    // Backpressure with a second request held by the requester.
    bus.out_ready = 1'b0;
    accept(1'b0, 32'd20, 32'd3);
    e.q = 32'd6;
    e.r = 32'd2;
    sb.push_back(e);
    wait_out(35, "lat_bp");
    bus.in_valid  = 1'b1;
    bus.in_signed = 1'b0;
    bus.dividend  = 32'd50;
    bus.divisor   = 32'd5;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_quotient", bus.quotient, 32'd6);
      check("bp_remainder", bus.remainder, 32'd2);
      check("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
      check("bp_out_valid", {31'b0, bus.out_valid}, 32'd1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_idle", {31'b0, bus.busy}, 32'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp_held_accept", {31'b0, bus.busy}, 32'd1);
    e.q = 32'd10;
    e.r = 32'd0;
    sb.push_back(e);
    wait_out(35, "lat_held");
    @(posedge clk); #1;

    // Flush in CALC cycle 10.
    accept(1'b0, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_calc_busy", {31'b0, bus.busy}, 32'd0);
    check("flush_calc_in_ready", {31'b0, bus.in_ready}, 32'd1);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1;
    end
    check("flush_calc_no_valid", 32'(seen), 32'd0);
    run_op(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 35, "lat_9_3_a");

    // Flush in DONE while out_ready is high: result dropped.
    accept(1'b0, 32'd9, 32'd4);
    wait_out(35, "lat_flush_done");
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_done_valid", {31'b0, bus.out_valid}, 32'd0);
    check("flush_done_busy", {31'b0, bus.busy}, 32'd0);
    run_op(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 35, "lat_9_3_b");

    // Reset mid-CALC.
    accept(1'b0, 32'd100, 32'd7);
    repeat (15) @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    check("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("midrst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("midrst_busy", {31'b0, bus.busy}, 32'd0);
    check("midrst_quotient", bus.quotient, 32'd0);
    check("midrst_remainder", bus.remainder, 32'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Flush coincident with a request in IDLE: no accept.
    bus.in_valid  = 1'b1;
    bus.in_signed = 1'b0;
    bus.dividend  = 32'd9;
    bus.divisor   = 32'd3;
    bus.flush     = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    check("flush_idle_busy", {31'b0, bus.busy}, 32'd0);
    check("flush_idle_in_ready", {31'b0, bus.in_ready}, 32'd1);
    run_op(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 35, "lat_9_3_c");

    repeat (5) @(posedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
